id_issue_queue: RTL

//  Decode-side instruction buffer between IF and EX of the MIPS pipeline. Holds up to DEPTH fetched
//  {pc,inst} pairs and issues them in order. A load-use scoreboard of LOAD_LAT stages blocks issue of
//  any instruction that reads a register still being loaded. Branch redirects flush the queue.

---
 rtl/id_issue_queue.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/id_issue_queue.sv
// In-order decode issue queue with a load-use scoreboard between IF and EX.
// Optional statistics counters are built when ID_ISSUE_STATS_EN is defined.
module id_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int INST_W   = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic                     hazard,
`ifdef ID_ISSUE_STATS_EN
    output logic [31:0]              stat_hazard_cycles,
    output logic [31:0]              stat_full_cycles,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_sb_v    [LOAD_LAT];
    logic [4:0]        r_sb_addr [LOAD_LAT];

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_sb_hit;
    logic [INST_W-1:0] w_head_inst;
    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic              w_rs_used;
    logic              w_rt_used;
    logic              w_is_load;

    function automatic logic f_rs_used(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000010, 6'b000011, 6'b001111: f_rs_used = 1'b0;
            6'b000000: f_rs_used = !(fn == 6'b000000 || fn == 6'b000010 || fn == 6'b000011);
            default:   f_rs_used = 1'b1;
        endcase
    endfunction

    function automatic logic f_rt_used(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000100, 6'b000101,
            6'b101011, 6'b101001, 6'b101000: f_rt_used = 1'b1;
            default:                         f_rt_used = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_load(input logic [5:0] op);
        case (op)
            6'b100011, 6'b100000, 6'b100100,
            6'b100001, 6'b100101: f_is_load = 1'b1;
            default:              f_is_load = 1'b0;
        endcase
    endfunction

    assign w_empty     = (r_count == {CW{1'b0}});
    assign w_head_inst = r_inst[r_rd_ptr];
    assign w_op        = w_head_inst[31:26];
    assign w_rs        = w_head_inst[25:21];
    assign w_rt        = w_head_inst[20:16];
    assign w_fn        = w_head_inst[5:0];
    assign w_rs_used   = f_rs_used(w_op, w_fn);
    assign w_rt_used   = f_rt_used(w_op);
    assign w_is_load   = f_is_load(w_op);

    // Head is blocked if any in-flight load targets a non-zero source it reads.
    always_comb begin
        w_sb_hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            w_sb_hit = w_sb_hit | (r_sb_v[i] && (r_sb_addr[i] != 5'd0) &&
                       ((w_rs_used && (r_sb_addr[i] == w_rs)) ||
                        (w_rt_used && (r_sb_addr[i] == w_rt))));
        end
    end

    assign in_ready  = (r_count < CW'(DEPTH));
    assign hazard    = !w_empty && w_sb_hit;
    assign out_valid = !w_empty && !w_sb_hit;
    assign out_pc    = w_empty ? {PC_W{1'b0}} : r_pc[r_rd_ptr];
    assign out_inst  = w_empty ? {INST_W{1'b0}} : w_head_inst;
    assign count     = r_count;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    // Pointer and occupancy tracking; flush empties the queue but the head pop still counts as issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= {PC_W{1'b0}};
                r_inst[i] <= {INST_W{1'b0}};
            end
        end else if (w_push) begin
            r_pc[r_wr_ptr]   <= in_pc;
            r_inst[r_wr_ptr] <= in_inst;
        end else begin
            r_pc[r_wr_ptr]   <= r_pc[r_wr_ptr];
            r_inst[r_wr_ptr] <= r_inst[r_wr_ptr];
        end
    end

    // Load scoreboard shifts only while EX advances; flush leaves in-flight loads alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                r_sb_v[i]    <= 1'b0;
                r_sb_addr[i] <= 5'd0;
            end
        end else if (out_ready) begin
            r_sb_v[0]    <= w_pop && w_is_load;
            r_sb_addr[0] <= (w_pop && w_is_load) ? w_rt : 5'd0;
            for (int i = 1; i < LOAD_LAT; i++) begin
                r_sb_v[i]    <= r_sb_v[i-1];
                r_sb_addr[i] <= r_sb_addr[i-1];
            end
        end else begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                r_sb_v[i]    <= r_sb_v[i];
                r_sb_addr[i] <= r_sb_addr[i];
            end
        end
    end

`ifdef ID_ISSUE_STATS_EN
    logic [31:0] r_stat_hazard;
    logic [31:0] r_stat_full;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_hazard <= 32'd0;
            r_stat_full   <= 32'd0;
        end else begin
            if (hazard && (r_stat_hazard != 32'hFFFF_FFFF)) begin
                r_stat_hazard <= r_stat_hazard + 32'd1;
            end else begin
                r_stat_hazard <= r_stat_hazard;
            end
            if (in_valid && !in_ready && (r_stat_full != 32'hFFFF_FFFF)) begin
                r_stat_full <= r_stat_full + 32'd1;
            end else begin
                r_stat_full <= r_stat_full;
            end
        end
    end

    assign stat_hazard_cycles = r_stat_hazard;
    assign stat_full_cycles   = r_stat_full;
`endif
endmodule
